// File: rtl/mux2to1_pkg.sv
// ---------------------------------------------------------------------------
// mux2to1_pkg
// Shared constants for the registered 2:1 multiplexer.
//   WIDTH_DEFAULT : default data width of the operands and the result
//   sel_e         : select-line encodings (SEL_A picks A, SEL_B picks B)
// ---------------------------------------------------------------------------
package mux2to1_pkg;

    localparam int unsigned WIDTH_DEFAULT = 9;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage : mux2to1_pkg

// File: rtl/mux2to1_cell.sv
// ---------------------------------------------------------------------------
// mux2to1_cell
// Purely combinational 2:1 selector, width parameterised.
// Ports:
//   a [WIDTH-1:0] : operand chosen when s selects A
//   b [WIDTH-1:0] : operand chosen when s selects B
//   s             : select line
//   y [WIDTH-1:0] : selected operand, bit-for-bit copy
// ---------------------------------------------------------------------------
module mux2to1_cell
    import mux2to1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: default assigned first so every path drives y -- no latch.
        y = a;
        // Only an explicit 1 selects B; anything else (0, X, Z) falls to A.
        if (sel_e'(s) == SEL_B) begin
            y = b;
        end
    end

endmodule : mux2to1_cell

// File: rtl/mux2to1_8.sv
// ---------------------------------------------------------------------------
// mux2to1_8
// Registered 2:1 multiplexer: one clock of latency, no combinational path
// from inputs to out_8.
// Ports:
//   clk               : single clock, rising-edge active
//   rst               : synchronous active-high reset, clears out_8
//   A     [WIDTH-1:0] : operand loaded when sel = 0
//   B     [WIDTH-1:0] : operand loaded when sel = 1
//   sel               : select line
//   out_8 [WIDTH-1:0] : registered selection result
// ---------------------------------------------------------------------------
module mux2to1_8
    import mux2to1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic [WIDTH-1:0] out_8
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    mux2to1_cell #(
        .WIDTH (WIDTH)
    ) u_cell (
        .a (A),
        .b (B),
        .s (sel),
        .y (out_d)
    );

    // Reset wins over the load; the first edge after release loads normally.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_8 = out_q;

endmodule : mux2to1_8

// File: tb/tb_mux2to1_8.sv
// ---------------------------------------------------------------------------
// tb_mux2to1_8
// Self-checking bench for mux2to1_8. Each driven cycle pushes its expected
// result onto a scoreboard; the value is popped and compared one edge later.
// ---------------------------------------------------------------------------
module tb_mux2to1_8;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sel;
    logic [W-1:0] out_8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] val;
    } exp_t;

    exp_t sb_q[$];

    mux2to1_8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .sel   (sel),
        .out_8 (out_8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // Reference behaviour of one clock edge.
    function automatic logic [W-1:0] model(input logic r, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic s);
        if (r) return '0;
        return s ? b : a;
    endfunction

    // Drive one cycle of stimulus, record its expectation, then compare
    // after the edge that should produce it.
    task automatic step(input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input string tag);
        exp_t e;
        rst = r;
        A   = a;
        B   = b;
        sel = s;
        e.tag = tag;
        e.val = model(r, a, b, s);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, out_8, e.val);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs, rr;

        // Scenario 1: reset held two cycles with B selected.
        step(1'b1, 9'd50, 9'd90, 1'b1, "rst_cycle0");
        step(1'b1, 9'd50, 9'd90, 1'b1, "rst_cycle1");

        // Scenario 2: release reset, A path.
        step(1'b0, 9'd0,  9'd0,  1'b0, "a_zero");
        step(1'b0, 9'd50, 9'd0,  1'b0, "a_50");

        // Scenario 3: unselected operand changes, output holds.
        step(1'b0, 9'd50, 9'd90, 1'b0, "b_unselected");
        @(negedge clk);
        check("hold_between_edges", out_8, 9'd50);
        @(posedge clk);
        #1;

        // Scenario 4: toggle select.
        step(1'b0, 9'd50, 9'd90, 1'b1, "sel_b_90");
        step(1'b0, 9'd50, 9'd90, 1'b0, "sel_a_50");

        // sel and selected operand change together.
        step(1'b0, 9'd50, 9'd77, 1'b1, "sel_and_b_same_cycle");

        // Scenario 5: width boundaries, every bit checked.
        step(1'b0, 9'd511, 9'd0, 1'b0, "a_all_ones");
        for (int i = 0; i < W; i++) begin
            check($sformatf("a_all_ones_bit%0d", i), {{(W-1){1'b0}}, out_8[i]},
                  {{(W-1){1'b0}}, 1'b1});
        end
        step(1'b0, 9'd511, 9'd0, 1'b1, "b_zero");
        step(1'b0, 9'd0, 9'd511, 1'b1, "b_all_ones");
        step(1'b0, 9'd0, 9'd511, 1'b0, "a_zero_again");
        step(1'b0, 9'h155, 9'h0AA, 1'b0, "a_alt_pattern");
        step(1'b0, 9'h155, 9'h0AA, 1'b1, "b_alt_pattern");

        // Scenario 6: reset mid-operation, then immediate resume.
        step(1'b0, 9'd50, 9'd90, 1'b1, "pre_rst_90");
        step(1'b1, 9'd50, 9'd90, 1'b1, "mid_rst_clear");
        step(1'b0, 9'd50, 9'd90, 1'b1, "post_rst_90");

        // Random traffic with occasional reset.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rr = ($urandom_range(0, 7) == 0);
            step(rr, ra, rb, rs, $sformatf("rand%0d", i));
        end

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0",
                     sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux2to1_8
